seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter DIVIDEND_WIDTH, default 32, sets the dividend and quotient width in bits.
REQ-002 Parameter DIVISOR_WIDTH, default 32, sets the divisor and remainder width in bits; DIVISOR_WIDTH <= DIVIDEND_WIDTH, checked at elaboration.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1 bit: an operand set is presented.
REQ-006 Port in_ready, output, 1 bit: the block can accept operands.
REQ-007 Port is_signed, input, 1 bit: 1 selects two's-complement division, 0 selects unsigned; sampled on accept.
REQ-008 Port dividend, input, DIVIDEND_WIDTH bits: sampled on accept.
REQ-009 Port divisor, input, DIVISOR_WIDTH bits: sampled on accept.
REQ-010 Port out_valid, output, 1 bit: a result is presented.
REQ-011 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 Port quotient, output, DIVIDEND_WIDTH bits: the quotient.
REQ-013 Port remainder, output, DIVISOR_WIDTH bits: the remainder.
REQ-014 Port div_by_zero, output, 1 bit: set when the divisor was 0.
REQ-015 Port overflow, output, 1 bit: set on signed MIN / -1.
REQ-016 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 States are IDLE, PREP, CALC, FIX and DONE; the block leaves reset in IDLE.
REQ-018 in_ready = 1 only in IDLE; an accept occurs at a rising edge where in_valid && in_ready, and moves IDLE to PREP.
REQ-019 PREP: when is_signed=1, take the absolute values of both operands and record the quotient sign (sign XOR) and the remainder sign (dividend sign); when is_signed=0, pass the operands unchanged.
REQ-020 CALC: perform exactly DIVIDEND_WIDTH restoring shift-subtract iterations, one per cycle, using an iteration counter that runs 0 to DIVIDEND_WIDTH-1.
REQ-021 FIX: apply the recorded signs to quotient and remainder (truncating division; remainder carries the dividend's sign; |remainder| < |divisor|), then go to DONE.
REQ-022 Normal latency: out_valid rises DIVIDEND_WIDTH+3 rising edges after the accepting edge (35 for the defaults).
REQ-023 Divide-by-zero (divisor == 0, either mode): skip CALC and FIX; PREP goes directly to DONE.
REQ-024 Divide-by-zero result: quotient = all ones, remainder = dividend[DIVISOR_WIDTH-1:0], div_by_zero = 1, out_valid 2 edges after accept.
REQ-025 Signed overflow (is_signed=1, dividend = most-negative value, divisor = all ones): skip CALC and FIX; result is quotient = dividend, remainder = 0, overflow = 1, out_valid 2 edges after accept.
REQ-026 DONE: out_valid = 1, and quotient, remainder, div_by_zero and overflow are held stable until out_valid && out_ready; that handshake returns the block to IDLE.
REQ-027 in_valid in any state other than IDLE is ignored; operand inputs may change freely after accept without affecting the result.
REQ-028 out_ready while out_valid = 0 has no effect.
REQ-029 The flags are mutually exclusive; both are 0 on a normal result.

Reset
REQ-030 rst_n low forces, asynchronously and in any state including mid-CALC: state = IDLE, out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, overflow = 0, busy = 0, iteration counter = 0; any in-flight operation is discarded.
REQ-031 in_ready = 1 while rst_n is low and after its release.
REQ-032 The first accept is possible at the first rising edge after rst_n rises.

Structure
REQ-033 Package divider_pkg holds the state enum type and the default width constants.
REQ-034 Sub-module div_step holds one combinational unsigned shift-subtract iteration (partial remainder and divisor in; next partial remainder and quotient bit out); seq_divider instantiates it once.

Verification
REQ-035 Unsigned 100/10 -> quotient = 10, remainder = 0, both flags 0, out_valid exactly 35 edges after accept.
REQ-036 Signed -50/10 -> quotient = 0xFFFFFFFB; signed 50/-7 -> quotient = -7, remainder = 1; signed -50/-7 -> quotient = 7, remainder = -1 (0xFFFFFFFF).
REQ-037 50/0 in both modes -> quotient = 0xFFFFFFFF, remainder = 50, div_by_zero = 1, out_valid 2 edges after accept.
REQ-038 0x80000000 / 0xFFFFFFFF: signed -> quotient = 0x80000000, remainder = 0, overflow = 1; unsigned -> quotient = 0, remainder = 0x80000000, overflow = 0.
REQ-039 Hold out_ready = 0 for 10 cycles in DONE -> outputs stable, in_ready = 0, and in_valid pulses are ignored; then out_ready = 1 -> IDLE on the next edge.
REQ-040 Assert rst_n low mid-CALC -> all outputs at their reset values immediately; after release, 0xFFFFFFFF/1 unsigned -> quotient = 0xFFFFFFFF, remainder = 0.

Source files
------------

// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and default widths for the sequential divider.
package divider_pkg;
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
    localparam int DEF_DIVIDEND_WIDTH = 32;
    localparam int DEF_DIVISOR_WIDTH  = 32;
endpackage

// File: rtl/div_step.sv
// div_step: one unsigned restoring shift-subtract iteration.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   partial,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] diff;
    // partial < 2*divisor, so a clear top bit means the subtraction fits
    assign diff     = partial - {1'b0, divisor};
    assign q_bit    = ~diff[W];
    assign rem_next = q_bit ? diff[W-1:0] : partial[W-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed/unsigned restoring divider with valid/ready handshakes.
module seq_divider
    import divider_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      is_signed,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero,
    output logic                      overflow,
    output logic                      busy
);
    localparam int N  = DIVIDEND_WIDTH;
    localparam int D  = DIVISOR_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (D > N) begin : g_width_check
        $error("DIVISOR_WIDTH must not exceed DIVIDEND_WIDTH");
    end

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [D-1:0]    dsr;
    logic            sgn;
    logic            q_neg;
    logic            r_neg;
    logic [D-1:0]    rem_next;
    logic            q_bit;

    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;

    // quotient doubles as the dividend shift register and remainder as the partial remainder
    div_step #(.W(D)) u_step (
        .partial  ({remainder, quotient[N-1]}),
        .divisor  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dsr         <= '0;
            sgn         <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    quotient    <= dividend;
                    dsr         <= divisor;
                    sgn         <= is_signed;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    state       <= PREP;
                end
                PREP: if (dsr == '0) begin
                    div_by_zero <= 1'b1;
                    remainder   <= quotient[D-1:0];
                    quotient    <= '1;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end else if (sgn && quotient == {1'b1, {(N-1){1'b0}}} && &dsr) begin
                    overflow  <= 1'b1;
                    remainder <= '0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    quotient  <= (sgn && quotient[N-1]) ? -quotient : quotient;
                    dsr       <= (sgn && dsr[D-1]) ? -dsr : dsr;
                    q_neg     <= sgn && (quotient[N-1] ^ dsr[D-1]);
                    r_neg     <= sgn && quotient[N-1];
                    remainder <= '0;
                    cnt       <= '0;
                    state     <= CALC;
                end
                CALC: begin
                    remainder <= rem_next;
                    quotient  <= {quotient[N-2:0], q_bit};
                    cnt       <= (cnt == CW'(N - 1)) ? '0 : cnt + 1'b1;
                    state     <= (cnt == CW'(N - 1)) ? FIX : CALC;
                end
                FIX: begin
                    quotient  <= q_neg ? -quotient : quotient;
                    remainder <= r_neg ? -remainder : remainder;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider at default widths.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;
    logic        busy;
    int checks = 0;
    int errors = 0;

    seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // accept edge counts as edge 1; latency is the edge after which out_valid is first seen
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = ~s;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || quotient !== 0 || remainder !== 0 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: rdy=%b busy=%b ov=%b q=%h r=%h dz=%b of=%b, required 1 0 0 0 0 0 0", in_ready, busy, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_unsigned();
        int lat;
        start_op(1'b0, 32'd100, 32'd10, lat);
        checks++;
        if (lat !== 35 || quotient !== 32'd10 || remainder !== 0 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL u_100_10: lat=%0d q=%h r=%h dz=%b of=%b, required 35 0000000a 0 0 0", lat, quotient, remainder, div_by_zero, overflow);
        end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL u_consume: rdy=%b ov=%b, required 1 0", in_ready, out_valid);
        end
        start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++;
        if (lat !== 35 || quotient !== 0 || remainder !== 32'h8000_0000 || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL u_min_ones: lat=%0d q=%h r=%h of=%b dz=%b, required 35 0 80000000 0 0", lat, quotient, remainder, overflow, div_by_zero);
        end
        consume();
    endtask

    task automatic test_signed();
        int lat;
        start_op(1'b1, -32'sd50, 32'sd10, lat);
        checks++;
        if (lat !== 35 || quotient !== 32'hFFFF_FFFB || remainder !== 0) begin
            errors++;
            $display("FAIL s_m50_10: lat=%0d q=%h r=%h, required 35 fffffffb 0", lat, quotient, remainder);
        end
        consume();
        start_op(1'b1, 32'sd50, -32'sd7, lat);
        checks++;
        if (quotient !== 32'hFFFF_FFF9 || remainder !== 32'd1 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL s_50_m7: q=%h r=%h dz=%b of=%b, required fffffff9 1 0 0", quotient, remainder, div_by_zero, overflow);
        end
        consume();
        start_op(1'b1, -32'sd50, -32'sd7, lat);
        checks++;
        if (quotient !== 32'd7 || remainder !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL s_m50_m7: q=%h r=%h, required 7 ffffffff", quotient, remainder);
        end
        consume();
    endtask

    task automatic test_div_zero();
        int lat;
        for (int m = 0; m < 2; m++) begin
            start_op(m[0], 32'd50, 32'd0, lat);
            checks++;
            if (lat !== 2 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd50 || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL div_zero_mode%0d: lat=%0d q=%h r=%h dz=%b of=%b, required 2 ffffffff 32 1 0", m, lat, quotient, remainder, div_by_zero, overflow);
            end
            consume();
        end
    endtask

    task automatic test_overflow();
        int lat;
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++;
        if (lat !== 2 || quotient !== 32'h8000_0000 || remainder !== 0 || overflow !== 1'b1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL s_overflow: lat=%0d q=%h r=%h of=%b dz=%b, required 2 80000000 0 1 0", lat, quotient, remainder, overflow, div_by_zero);
        end
        consume();
        start_op(1'b0, 32'd9, 32'd4, lat);
        checks++;
        if (quotient !== 32'd2 || remainder !== 32'd1 || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL flags_clear: q=%h r=%h of=%b dz=%b, required 2 1 0 0", quotient, remainder, overflow, div_by_zero);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        start_op(1'b0, 32'd7, 32'd2, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid  = i[0];
            dividend  = 32'd1000 + i;
            divisor   = 32'd3;
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            if (quotient !== 32'd3 || remainder !== 32'd1 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles (q=%h r=%h ov=%b rdy=%b), required 0", bad, quotient, remainder, out_valid, in_ready);
        end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: rdy=%b ov=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        @(negedge clk);
        is_signed = 1'b0;
        dividend  = 32'd12345;
        divisor   = 32'd7;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || quotient !== 0 || remainder !== 0 || div_by_zero !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_calc: ov=%b q=%h r=%h dz=%b of=%b busy=%b rdy=%b, required 0 0 0 0 0 0 1", out_valid, quotient, remainder, div_by_zero, overflow, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(1'b0, 32'hFFFF_FFFF, 32'd1, lat);
        checks++;
        if (lat !== 35 || quotient !== 32'hFFFF_FFFF || remainder !== 0) begin
            errors++;
            $display("FAIL after_reset: lat=%0d q=%h r=%h, required 35 ffffffff 0", lat, quotient, remainder);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_calc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
